// File: rtl/multiple_gates_pkg.sv
// -----------------------------------------------------------------------------
// multiple_gates_pkg
//   Shared types and constants for the registered two-input gate bank.
//   gate_in_t    : 2-bit operand pair, A = bit 1, B = bit 0.
//   gate_out_t   : the six gate results, MSB first in NOT_A/OR/AND/NOR/XOR/XNOR
//                  order.
//   GATE_OUT_RST : result pattern for operand 2'b00, used as the reset value.
// -----------------------------------------------------------------------------
package multiple_gates_pkg;

    typedef logic [1:0] gate_in_t;

    typedef struct packed {
        logic not_a;
        logic or_o;
        logic and_o;
        logic nor_o;
        logic xor_o;
        logic xnor_o;
    } gate_out_t;

    localparam gate_out_t GATE_OUT_RST = '{
        not_a:  1'b1,
        or_o:   1'b0,
        and_o:  1'b0,
        nor_o:  1'b1,
        xor_o:  1'b0,
        xnor_o: 1'b1
    };

endpackage : multiple_gates_pkg

// File: rtl/multiple_gates_gate2.sv
// -----------------------------------------------------------------------------
// gate2
//   Purely combinational evaluation of six Boolean functions of A and B.
//   Ports:
//     in  : gate_in_t  operand pair {A, B}
//     out : gate_out_t {NOT_A, OR, AND, NOR, XOR, XNOR}
// -----------------------------------------------------------------------------
module gate2
    import multiple_gates_pkg::*;
(
    input  gate_in_t  in,
    output gate_out_t out
);

    logic w_a;
    logic w_b;

    assign w_a = in[1];
    assign w_b = in[0];

    always_comb begin
        // NOTE: a full default assignment up front guarantees every field is
        // written on every evaluation, so no latch can be inferred.
        out        = '0;
        out.not_a  = ~w_a;
        out.or_o   = w_a | w_b;
        out.and_o  = w_a & w_b;
        out.nor_o  = ~(w_a | w_b);
        out.xor_o  = w_a ^ w_b;
        out.xnor_o = ~(w_a ^ w_b);
    end

endmodule : gate2

// File: rtl/multiple_gates.sv
// -----------------------------------------------------------------------------
// multiple_gates
//   Registered two-input gate bank. The operand pair is sampled every rising
//   clock edge and six gate functions of the sampled value are presented.
//   Build option MULTIPLE_GATES_OUT_REG_EN adds an output register (2-cycle
//   latency instead of 1). Reset values are the 00-row in both builds.
//   Ports:
//     clk     : rising-edge clock
//     rst     : asynchronous, active-high reset
//     entrada : operand pair, A = entrada[1], B = entrada[0]
//     NOT_A, OR, AND, NOR, XOR, XNOR : gate results of the sampled operand
// -----------------------------------------------------------------------------
module multiple_gates
    import multiple_gates_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] entrada,
    output logic       NOT_A,
    output logic       OR,
    output logic       AND,
    output logic       NOR,
    output logic       XOR,
    output logic       XNOR
);

    gate_in_t  r_in_q;
    gate_out_t w_gate;
    gate_out_t w_out;

    // Operand register loads every cycle; reset clears it so the outputs
    // settle on the 00 row without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_q <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps register updates ordered
            // correctly with respect to every other clocked process.
            r_in_q <= entrada;
        end
    end

    gate2 u_gate2 (
        .in  (r_in_q),
        .out (w_gate)
    );

`ifdef MULTIPLE_GATES_OUT_REG_EN
    gate_out_t r_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q <= GATE_OUT_RST;
        end else begin
            r_out_q <= w_gate;
        end
    end

    assign w_out = r_out_q;
`else
    // Gate logic driven only by a register, so outputs are still glitch-free
    // relative to entrada.
    assign w_out = w_gate;
`endif

    assign NOT_A = w_out.not_a;
    assign OR    = w_out.or_o;
    assign AND   = w_out.and_o;
    assign NOR   = w_out.nor_o;
    assign XOR   = w_out.xor_o;
    assign XNOR  = w_out.xnor_o;

endmodule : multiple_gates

// File: tb/tb_multiple_gates.sv
// -----------------------------------------------------------------------------
// tb_multiple_gates
//   Directed self-checking bench for multiple_gates. Expected result rows are
//   pushed to a scoreboard queue as each operand is clocked in and popped when
//   the design's latency has elapsed. Outputs are sampled 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_multiple_gates;

`ifdef MULTIPLE_GATES_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Row order: NOT_A/OR/AND/NOR/XOR/XNOR
    localparam logic [5:0] ROW_RST = 6'b100101;

    logic       clk;
    logic       rst;
    logic [1:0] entrada;
    logic       NOT_A, OR, AND, NOR, XOR, XNOR;

    int total = 0;
    int bad   = 0;
    logic [5:0] sb[$];

    multiple_gates dut (
        .clk     (clk),
        .rst     (rst),
        .entrada (entrada),
        .NOT_A   (NOT_A),
        .OR      (OR),
        .AND     (AND),
        .NOR     (NOR),
        .XOR     (XOR),
        .XNOR    (XNOR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference truth table, indexed by the operand value mod 4.
    function automatic logic [5:0] exp_row(input int v);
        logic [5:0] r;
        case (v % 4)
            0:       r = 6'b100101;
            1:       r = 6'b110010;
            2:       r = 6'b010010;
            default: r = 6'b011001;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] obs_row();
        return {NOT_A, OR, AND, NOR, XOR, XNOR};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // NOR==~OR, XNOR==~XOR, AND implies OR -> all three flags must be 1.
    task automatic check_inv(input string tag);
        logic [5:0] inv;
        inv = {3'b000, NOR ^ OR, XNOR ^ XOR, ~(AND & ~OR)};
        check(tag, inv, 6'b000111);
    endtask

    // Drive v during the low phase, clock it in, then compare the oldest
    // scoreboard entry once it is due.
    task automatic step(input int v, input string tag);
        @(negedge clk);
        entrada = 2'(v);
        @(posedge clk);
        sb.push_back(exp_row(v));
        #1;
        if (sb.size() >= LAT) check(tag, obs_row(), sb.pop_front());
        check_inv({tag, "_inv"});
    endtask

    initial begin
        rst     = 1'b1;
        entrada = 2'b11;

        // Reset hold: 00 row before any clock and across edges.
        #1;
        check("rst_async", obs_row(), ROW_RST);
        check_inv("rst_inv");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold", obs_row(), ROW_RST);
        end

        @(negedge clk);
        rst = 1'b0;
        sb.delete();

        // Exhaustive sweep.
        for (int v = 0; v < 4; v++) step(v, "sweep");

        // Truncation of integers to 2 bits.
        for (int v = 0; v < 10; v++) step(v, "trunc");

        // Mid-stream reset pulse between edges.
        repeat (LAT) step(3, "pre_rst");
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst", obs_row(), ROW_RST);
        check_inv("mid_rst_inv");
        sb.delete();
        #1;
        rst = 1'b0;
        repeat (LAT) step(3, "recover");

        // Glitch rejection: only the value at the edge is captured.
        @(negedge clk);
        entrada = 2'b01;
        #1 entrada = 2'b10;
        #1 entrada = 2'b01;
        @(posedge clk);
        sb.push_back(exp_row(1));
        #1;
        if (sb.size() >= LAT) check("glitch_01", obs_row(), sb.pop_front());

        @(negedge clk);
        entrada = 2'b10;
        #1 entrada = 2'b01;
        #1 entrada = 2'b10;
        @(posedge clk);
        sb.push_back(exp_row(2));
        #1;
        if (sb.size() >= LAT) check("glitch_10", obs_row(), sb.pop_front());

        // Drain any entries still in flight.
        repeat (LAT) step(0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multiple_gates
